// File: rtl/key_switch_pkg.sv
// ---------------------------------------------------------------------------
// key_switch_pkg
//   Shared definitions for the key/switch reader peripheral: Avalon word
//   addresses of the register map and the bus data width.
// ---------------------------------------------------------------------------
package key_switch_pkg;

    localparam int BUS_W = 32;

    typedef logic [1:0] reg_addr_t;

    localparam reg_addr_t REG_DATA = 2'd0;  // debounced state, read-only
    localparam reg_addr_t REG_EDGE = 2'd1;  // sticky press flags, write-1-to-clear
    localparam reg_addr_t REG_MASK = 2'd2;  // per-input IRQ enable
    localparam reg_addr_t REG_RSVD = 2'd3;  // reserved, reads 0

endpackage

// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------------------
// input_debouncer
//   One raw pin: 2-flop synchroniser, polarity normalisation (1 = pressed),
//   and a hold counter that accepts a new level only after it has been seen
//   for DEBOUNCE_CYCLES consecutive cycles.
// Ports
//   i_clk     system clock
//   i_rst     asynchronous active-high reset
//   i_raw     asynchronous pin input
//   o_stable  debounced level, 1 = pressed
//   o_press   one-cycle pulse on the cycle the stable level will go 0->1
// ---------------------------------------------------------------------------
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_stable,
    output logic o_press
);

    localparam int   CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             w_s;
    logic             w_accept;

    assign w_s      = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
    // New level has been held long enough: stable takes it on this edge.
    assign w_accept = (w_s != r_stable) && (r_cnt == CNT_LAST);
    assign o_press  = w_accept && w_s;
    assign o_stable = r_stable;

    // Synchroniser flops reset to the idle pin level so the first sampled
    // value after reset is "not pressed" and no edge is fabricated.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= IDLE_LVL;
            r_sync2 <= IDLE_LVL;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (w_s == r_stable) begin
            // Any return to the stable level restarts the hold count.
            r_cnt <= '0;
        end else if (w_accept) begin
            r_stable <= w_s;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/key_switch_reader.sv
// ---------------------------------------------------------------------------
// key_switch_reader
//   Avalon-MM read-side peripheral for push-buttons / slide switches.
//   Debounces N_INPUTS raw pins, exposes the debounced state, latches press
//   events in a sticky W1C register and raises a maskable level interrupt.
// Ports
//   clk_50Mhz  system clock
//   reset      asynchronous active-high reset
//   address    Avalon word address (0 DATA, 1 EDGE, 2 MASK, 3 reserved)
//   read       Avalon read strobe
//   write      Avalon write strobe
//   writedata  Avalon write data
//   readdata   Avalon read data, fixed read latency 1, 0 when not reading
//   irq        level interrupt, |(EDGE & MASK), registered
//   raw_in     asynchronous pin inputs
// ---------------------------------------------------------------------------
module key_switch_reader
    import key_switch_pkg::*;
#(
    parameter int N_INPUTS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                clk_50Mhz,
    input  logic                reset,
    input  logic [1:0]          address,
    input  logic                read,
    input  logic                write,
    input  logic [BUS_W-1:0]    writedata,
    output logic [BUS_W-1:0]    readdata,
    output logic                irq,
    input  logic [N_INPUTS-1:0] raw_in
);

    logic [N_INPUTS-1:0] w_stable;
    logic [N_INPUTS-1:0] w_press;
    logic [N_INPUTS-1:0] w_w1c;
    logic [N_INPUTS-1:0] w_edge_next;
    logic [BUS_W-1:0]    w_rd_mux;
    logic [N_INPUTS-1:0] r_edge;
    logic [N_INPUTS-1:0] r_mask;

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_deb
        input_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_deb (
            .i_clk    (clk_50Mhz),
            .i_rst    (reset),
            .i_raw    (raw_in[g]),
            .o_stable (w_stable[g]),
            .o_press  (w_press[g])
        );
    end

    if (N_INPUTS < BUS_W) begin : g_unused
        logic w_unused_wdata;
        assign w_unused_wdata = ^writedata[BUS_W-1:N_INPUTS];
    end

    assign w_w1c = (write && (address == REG_EDGE)) ? writedata[N_INPUTS-1:0] : '0;
    // Clear first, then OR in new presses so a press landing on the same
    // cycle as its clear is not lost.
    assign w_edge_next = (r_edge & ~w_w1c) | w_press;

    always_comb begin
        w_rd_mux = '0;
        case (address)
            REG_DATA: w_rd_mux[N_INPUTS-1:0] = w_stable;
            REG_EDGE: w_rd_mux[N_INPUTS-1:0] = r_edge;
            REG_MASK: w_rd_mux[N_INPUTS-1:0] = r_mask;
            default:  w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_50Mhz or posedge reset) begin
        if (reset) begin
            readdata <= '0;
            r_edge   <= '0;
            r_mask   <= '0;
            irq      <= 1'b0;
        end else begin
            // The mux sees pre-write register values, so a read paired with
            // a write returns the old contents.
            readdata <= read ? w_rd_mux : '0;
            r_edge   <= w_edge_next;
            if (write && (address == REG_MASK)) begin
                r_mask <= writedata[N_INPUTS-1:0];
            end
            irq <= |(r_edge & r_mask);
        end
    end

endmodule
